lz77_stream_decoder: RTL and testbench
======================================

// Module: lz77_stream_decoder
// PURPOSE
//  Parametrised LZ77 decoder: expands (pos,len,char) codes into a byte stream with valid/ready on both sides.
//  - Search-buffer depth, char width, length width and end marker are configurable.
//  - Downstream backpressure is supported.
//  - Sits between the code source (testbench or unpacker) and the output char sink.
// PARAMETERS
//  DW        8      char width (bits)
//  SB_DEPTH  9      search-buffer entries (>=2)
//  POS_W     4      code_pos width; 2**POS_W >= SB_DEPTH
//  LEN_W     3      code_len width
//  END_CHAR  8'h24  literal that terminates the stream ('$')
// PORTS
//  clk         in   1      clock
//  reset       in   1      synchronous, active-high
//  code_valid  in   1      code triple valid
//  code_ready  out  1      decoder accepts a code this cycle
//  code_pos    in   POS_W  copy offset into search buffer (0 = newest char)
//  code_len    in   LEN_W  number of copied chars before the literal
//  chardata    in   DW     literal char following the copy
//  out_valid   out  1      char_nxt valid
//  out_ready   in   1      sink accepts char_nxt
//  char_nxt    out  DW     decoded char
//  finish      out  1      END_CHAR has been emitted; sticky
//  err         out  1      sticky code error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, char_nxt=0, finish=0, err=0, code_ready=0 during reset.
//    All search-buffer entries and the fill count are set to 0. Reset mid-stream aborts the current code and drops any held char.
//  - States:
//    - IDLE: code_ready=1 (combinational on state).
//      Fire = code_valid&&code_ready; it latches pos, len, char and sets rem=len.
//      Go to COPY if len!=0, else LIT.
//    - COPY: each advance emits buf[pos].
//    - LIT: one advance emits the latched char.
//      Then go to DONE if the char==END_CHAR, else IDLE.
//    - DONE: code_ready=0, out_valid drops after the final handshake, finish stays 1 until reset.
//  - Advance condition: !out_valid || out_ready.
//    On advance: char_nxt<=emitted char, out_valid<=1, buf[i]<=buf[i-1], buf[0]<=emitted char.
//    In COPY, rem decrements; go to LIT when rem==1.
//  - With no advance (out_valid&&!out_ready): char_nxt, buffer, rem and state all hold.
//  - out_valid falls when out_ready=1 and no new char is produced that cycle, e.g. in IDLE.
//  - Latency: code accepted at cycle N -> first out_valid at N+1.
//    A code with len L yields L+1 chars in L+1 cycles with out_ready=1. There is one idle accept cycle per code.
//  - Overlap: pos indexes the buffer after the previous shift, so runs with pos<len replicate correctly.
//    Example: pos=0, len=3 repeats the newest char three times.
//  - finish rises in the same cycle as out_valid for the END_CHAR char.
//  - pos>=SB_DEPTH: the copied value is 0.
//  - Width rule: rem is LEN_W bits. A fill counter (ceil(log2(SB_DEPTH+1)) bits) counts emitted chars and saturates at SB_DEPTH.
// CONFIGURATION
//  LZ77_DEC_ERRCHK_EN defined:
//   - On code accept with len!=0, err<=1 (sticky) if pos>=fill or pos>=SB_DEPTH.
//   - Decoding continues unchanged; err clears only on reset.
//  LZ77_DEC_ERRCHK_EN undefined: err tied to 0 and the fill counter is omitted.
// TESTING
//  1. Literals only: codes (0,0,'a'),(0,0,'b'),(0,0,'$') -> chars a,b,$, finish=1 with the '$' beat, code_ready=0 afterwards.
//  2. Copy: after "abc", code (2,3,'d') -> a,b,c,a,b,c,d.
//     Overlap: after "x", code (0,4,'y') -> x,x,x,x,x,y.
//  3. Backpressure: out_ready low for 3 cycles mid-copy -> char_nxt stable and no chars lost or duplicated; the stream matches test 2.
//  4. Reset mid-COPY of code (1,5,'z') -> the next cycle has out_valid=0, finish=0, code_ready=1 and all buffer entries 0.
//  5. ERRCHK_EN: first code (3,2,'q') with fill=0 -> err=1 sticky, output 0,0,q.
//     Without the macro, err stays 0.
//  6. Param sweep SB_DEPTH=16, POS_W=4, LEN_W=4: code (15,15,'$') after 16 literals -> 15 correct copies then '$', and finish is asserted.

Source files
------------

// File: rtl/lz77_stream_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : lz77_stream_decoder                                               |
// | Brief   : Expands (pos,len,char) LZ77 codes into a byte stream, valid/ready |
// |           on both sides. Optional code checking: LZ77_DEC_ERRCHK_EN.        |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module lz77_stream_decoder #(
    parameter int              DW       = 8,
    parameter int              SB_DEPTH = 9,
    parameter int              POS_W    = 4,
    parameter int              LEN_W    = 3,
    parameter logic [DW-1:0]   END_CHAR = 8'h24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic [POS_W-1:0] code_pos,
    input  logic [LEN_W-1:0] code_len,
    input  logic [DW-1:0]    chardata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    char_nxt,
    output logic             finish,
    output logic             err
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_copy = 2'd1;
    localparam logic [1:0] c_st_lit  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]       r_state;
    logic [POS_W-1:0] r_pos;
    logic [LEN_W-1:0] r_rem;
    logic [DW-1:0]    r_char;
    logic [DW-1:0]    r_buf [SB_DEPTH];
    logic [DW-1:0]    r_char_nxt;
    logic             r_out_valid;
    logic             r_finish;

    logic             w_fire;
    logic             w_advance;
    logic             w_emit;
    logic [DW-1:0]    w_copy_char;
    logic [DW-1:0]    w_emit_char;

    assign code_ready = ~reset & (r_state == c_st_idle);
    assign w_fire     = code_valid & code_ready;
    assign w_advance  = ~r_out_valid | out_ready;
    assign w_emit     = w_advance & ((r_state == c_st_copy) | (r_state == c_st_lit));

    // Offsets beyond the buffer read as zero.
    always_comb begin
        w_copy_char = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (32'(r_pos) == i) w_copy_char = r_buf[i];
        end
    end

    assign w_emit_char = (r_state == c_st_lit) ? r_char : w_copy_char;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_pos       <= '0;
            r_rem       <= '0;
            r_char      <= '0;
            r_char_nxt  <= '0;
            r_out_valid <= 1'b0;
            r_finish    <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) r_buf[i] <= '0;
        end else begin
            if (out_ready) r_out_valid <= 1'b0;
            if (w_emit) begin
                r_char_nxt  <= w_emit_char;
                r_out_valid <= 1'b1;
                r_buf[0]    <= w_emit_char;
                for (int i = 1; i < SB_DEPTH; i++) r_buf[i] <= r_buf[i-1];
            end
            case (r_state)
                c_st_idle: begin
                    if (w_fire) begin
                        r_pos   <= code_pos;
                        r_rem   <= code_len;
                        r_char  <= chardata;
                        r_state <= (code_len != '0) ? c_st_copy : c_st_lit;
                    end
                end
                c_st_copy: begin
                    if (w_advance) begin
                        r_rem <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) r_state <= c_st_lit;
                    end
                end
                c_st_lit: begin
                    if (w_advance) begin
                        if (r_char == END_CHAR) begin
                            r_finish <= 1'b1;
                            r_state  <= c_st_done;
                        end else begin
                            r_state  <= c_st_idle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign char_nxt  = r_char_nxt;
    assign finish    = r_finish;

`ifdef LZ77_DEC_ERRCHK_EN
    localparam int c_fill_w = $clog2(SB_DEPTH + 1);

    logic [c_fill_w-1:0] r_fill;
    logic                r_err;

    // A copy may only reach back over chars that have actually been emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_emit && (r_fill != c_fill_w'(SB_DEPTH))) r_fill <= r_fill + c_fill_w'(1);
            if (w_fire && (code_len != '0) &&
                ((32'(code_pos) >= 32'(r_fill)) || (32'(code_pos) >= SB_DEPTH)))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lz77_stream_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_lz77_stream_decoder                                            |
// | Brief   : Scoreboard bench for lz77_stream_decoder (default and 16-deep).   |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lz77_stream_decoder;

    localparam int SB  = 9;
    localparam int PW  = 4;
    localparam int LW  = 3;
    localparam int SB2 = 16;
    localparam logic [7:0] c_end = 8'h24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          code_valid = 1'b0;
    logic          code_ready;
    logic [PW-1:0] code_pos = '0;
    logic [LW-1:0] code_len = '0;
    logic [7:0]    chardata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    char_nxt;
    logic          finish;
    logic          err;

    logic          code_valid2 = 1'b0;
    logic          code_ready2;
    logic [3:0]    code_pos2 = '0;
    logic [3:0]    code_len2 = '0;
    logic [7:0]    chardata2 = '0;
    logic          out_valid2;
    logic          out_ready2 = 1'b1;
    logic [7:0]    char_nxt2;
    logic          finish2;
    logic          err2;

    lz77_stream_decoder dut (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
        .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
        .out_valid(out_valid), .out_ready(out_ready), .char_nxt(char_nxt),
        .finish(finish), .err(err)
    );

    lz77_stream_decoder #(.DW(8), .SB_DEPTH(SB2), .POS_W(4), .LEN_W(4), .END_CHAR(8'h24)) dut2 (
        .clk(clk), .reset(reset), .code_valid(code_valid2), .code_ready(code_ready2),
        .code_pos(code_pos2), .code_len(code_len2), .chardata(chardata2),
        .out_valid(out_valid2), .out_ready(out_ready2), .char_nxt(char_nxt2),
        .finish(finish2), .err(err2)
    );

    typedef struct {
        logic [7:0] ch;
        logic       fin;
        logic       chk_err;
        logic       err;
    } exp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       sb[$];
    exp_t       sb2[$];
    logic [7:0] hist[$];
    logic       m_err = 1'b0;
    int         bp_mode = 0;
    int         stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a copy at offset pos takes the char pos+1 places back in the
    // output stream; anything older than the buffer depth or never written is 0.
    task automatic model_code(input int pos, input int len, input logic [7:0] ch);
        logic [7:0] c;
`ifdef LZ77_DEC_ERRCHK_EN
        int fill;
        fill = (hist.size() < SB) ? hist.size() : SB;
        if (len != 0 && (pos >= fill || pos >= SB)) m_err = 1'b1;
`endif
        for (int k = 0; k < len; k++) begin
            c = (pos < SB && pos < hist.size()) ? hist[hist.size() - 1 - pos] : 8'h00;
            hist.push_back(c);
            sb.push_back('{ch: c, fin: 1'b0, chk_err: (k == 0), err: m_err});
        end
        hist.push_back(ch);
        sb.push_back('{ch: ch, fin: (ch == c_end), chk_err: 1'b0, err: m_err});
    endtask

    task automatic send_code(input int pos, input int len, input logic [7:0] ch);
        int guard = 0;
        code_pos   = PW'(pos);
        code_len   = LW'(len);
        chardata   = ch;
        code_valid = 1'b1;
        while (!code_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!code_ready) begin
            n_fail++;
            $display("FAIL code_accept: code_ready stayed %0b, expected 1", code_ready);
        end else begin
            model_code(pos, len, ch);
        end
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_idle_valid"}, {31'd0, out_valid}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        hist.delete();
        m_err = 1'b0;
        @(negedge clk);
        check("ready_in_reset", {31'd0, code_ready}, 0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_char_nxt", {24'd0, char_nxt}, 0);
        check("rst_finish", {31'd0, finish}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_code_ready", {31'd0, code_ready}, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if (bp_mode != 0) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops one expectation per output handshake and checks holds.
    initial begin
        exp_t       e;
        logic [7:0] held;
        logic       held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_valid", {31'd0, out_valid}, 1);
                    check("hold_char", {24'd0, char_nxt}, {24'd0, held});
                end
                held_v = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got char %0h, expected no output", char_nxt);
                    end else begin
                        e = sb.pop_front();
                        check("char", {24'd0, char_nxt}, {24'd0, e.ch});
                        check("finish", {31'd0, finish}, {31'd0, e.fin});
                        if (e.chk_err) check("err", {31'd0, err}, {31'd0, e.err});
                    end
                end else if (out_valid) begin
                    held   = char_nxt;
                    held_v = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid2 && out_ready2) begin
                if (sb2.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out2: got char %0h, expected no output", char_nxt2);
                end else begin
                    e = sb2.pop_front();
                    check("char2", {24'd0, char_nxt2}, {24'd0, e.ch});
                    check("finish2", {31'd0, finish2}, {31'd0, e.fin});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] lits[16];
        logic [7:0] s2[$];
        int         guard;

        do_reset();

        // Literals only
        send_code(0, 0, "a");
        send_code(0, 0, "b");
        send_code(0, 0, "$");
        drain("lit");
        check("lit_finish_sticky", {31'd0, finish}, 1);
        check("lit_done_ready", {31'd0, code_ready}, 0);

        // Copy, overlap and a 3-cycle stall mid-copy
        do_reset();
        send_code(0, 0, "a");
        send_code(0, 0, "b");
        send_code(0, 0, "c");
        send_code(2, 3, "d");
        @(negedge clk);
        stall = 3;
        send_code(0, 0, "x");
        send_code(0, 4, "y");
        drain("copy");
        check("copy_finish", {31'd0, finish}, 0);

        // Reset in the middle of a copy, then a copy that reads the cleared buffer
        do_reset();
        send_code(0, 0, "m");
        send_code(1, 5, "z");
        @(negedge clk);
        @(negedge clk);
        do_reset();
        send_code(3, 2, "q");
        drain("errchk");
        check("err_sticky", {31'd0, err}, {31'd0, m_err});

        // Randomised streams with random backpressure
        for (int s = 0; s < 4; s++) begin
            do_reset();
            bp_mode = 1;
            for (int i = 0, n = $urandom_range(8, 14); i < n; i++)
                send_code($urandom_range(0, 15), $urandom_range(0, 7), 8'($urandom_range(97, 122)));
            send_code($urandom_range(0, 15), $urandom_range(0, 7), "$");
            drain("rand");
            check("rand_finish", {31'd0, finish}, 1);
            check("rand_err", {31'd0, err}, {31'd0, m_err});
            bp_mode = 0;
        end

        // 16-deep instance: 16 literals then a maximal far copy
        do_reset();
        for (int i = 0; i < 16; i++) lits[i] = 8'($urandom_range(97, 122));
        for (int i = 0; i < 17; i++) begin
            code_pos2   = (i == 16) ? 4'd15 : 4'd0;
            code_len2   = (i == 16) ? 4'd15 : 4'd0;
            chardata2   = (i == 16) ? c_end : lits[i];
            code_valid2 = 1'b1;
            guard = 0;
            while (!code_ready2 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            check("accept2", {31'd0, code_ready2}, 1);
            if (i < 16) begin
                s2.push_back(lits[i]);
                sb2.push_back('{ch: lits[i], fin: 1'b0, chk_err: 1'b0, err: 1'b0});
            end else begin
                for (int k = 0; k < 15; k++) begin
                    s2.push_back(s2[s2.size() - 16]);
                    sb2.push_back('{ch: s2[s2.size() - 1], fin: 1'b0, chk_err: 1'b0, err: 1'b0});
                end
                sb2.push_back('{ch: c_end, fin: 1'b1, chk_err: 1'b0, err: 1'b0});
            end
            @(negedge clk);
            code_valid2 = 1'b0;
        end
        guard = 0;
        while ((sb2.size() != 0 || out_valid2) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check("deep_drain", sb2.size(), 0);
        check("deep_finish", {31'd0, finish2}, 1);
        check("deep_err", {31'd0, err2}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
